// File: rtl/byte_serializer_if.sv
// Byte handshake bundle between the selector mux and the serializer.
// Upstream drives din/din_valid, the serializer returns din_ready.
interface byte_serializer_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;

   modport master (
      output din,
      output din_valid,
      input  din_ready
   );

   modport slave (
      input  din,
      input  din_valid,
      output din_ready
   );
endinterface

// File: rtl/byte_serializer.sv
// byte_serializer: start bit, LSB-first data, stop bit on one serial line.
// Define BYTE_SERIALIZER_PARITY_EN to insert an even-parity bit before stop.
module byte_serializer #(
   parameter int DATA_W = 8,
   parameter int DIV    = 4
) (
   input  logic             clk,
   input  logic             reset,
   byte_serializer_if.slave up,
   output logic             sout,
   output logic             busy,
   output logic             done
);
   localparam int CW = 16;
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
   localparam logic [BW-1:0] BMAX = BW'(DATA_W - 1);

`ifdef BYTE_SERIALIZER_PARITY_EN
   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP
   } state_t;
`endif

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [BW-1:0]     bcnt, bcnt_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              rdy, rdy_n;
   logic              sout_n, busy_n, done_n;
   logic              wrap;
`ifdef BYTE_SERIALIZER_PARITY_EN
   logic              par, par_n;
`endif

   assign up.din_ready = rdy;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         bcnt  <= '0;
         shreg <= '0;
         rdy   <= 1'b1;
         sout  <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
         par   <= 1'b0;
`endif
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         bcnt  <= bcnt_n;
         shreg <= shreg_n;
         rdy   <= rdy_n;
         sout  <= sout_n;
         busy  <= busy_n;
         done  <= done_n;
`ifdef BYTE_SERIALIZER_PARITY_EN
         par   <= par_n;
`endif
      end
   end

   // Outputs are computed for the next state so they come out registered.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bcnt_n  = bcnt;
      shreg_n = shreg;
      rdy_n   = rdy;
      sout_n  = sout;
      busy_n  = busy;
      done_n  = 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
      par_n   = par;
`endif
      wrap = (cnt == CMAX);
      if (state != IDLE) begin
         cnt_n = wrap ? '0 : cnt + CW'(1);
      end
      unique case (state)
         IDLE: begin
            if (up.din_valid && rdy) begin
               state_n = START;
               shreg_n = up.din;
               cnt_n   = '0;
               bcnt_n  = '0;
               rdy_n   = 1'b0;
               sout_n  = 1'b0;
               busy_n  = 1'b1;
`ifdef BYTE_SERIALIZER_PARITY_EN
               par_n   = ^up.din;
`endif
            end
         end
         START: begin
            if (wrap) begin
               state_n = DATA;
               sout_n  = shreg[0];
            end
         end
         DATA: begin
            if (wrap) begin
               if (bcnt == BMAX) begin
`ifdef BYTE_SERIALIZER_PARITY_EN
                  state_n = PARITY;
                  sout_n  = par;
`else
                  state_n = STOP;
                  sout_n  = 1'b1;
`endif
               end else begin
                  bcnt_n  = bcnt + BW'(1);
                  shreg_n = shreg >> 1;
                  sout_n  = shreg_n[0];
               end
            end
         end
`ifdef BYTE_SERIALIZER_PARITY_EN
         PARITY: begin
            if (wrap) begin
               state_n = STOP;
               sout_n  = 1'b1;
            end
         end
`endif
         STOP: begin
            if (wrap) begin
               state_n = IDLE;
               sout_n  = 1'b1;
               busy_n  = 1'b0;
               rdy_n   = 1'b1;
               done_n  = 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end
endmodule

// File: doc/byte_serializer.md
Name: byte_serializer

Overview:
- Downstream stage of the 8-bit selector datapath: consumes the selected byte and transmits it as an asynchronous-style serial frame on a single line.
- Frame format: start bit (0), data bits LSB first, stop bit (1).
- A valid/ready handshake latches the byte. An internal FSM plus a bit-period counter generate the frame.
- Sits between the 8-bit mux output and an off-chip/serial consumer.

Parameters:
- DATA_W, 8, data bits per frame.
- DIV, 4, clock cycles per serial bit. Legal range is 1..65535; DIV=1 is legal.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  DATA_W  byte to send (mux output).
- din_valid  input  1  din holds a byte to send.
- din_ready  output  1  block can accept a byte this cycle.
- sout  output  1  serial line; idle level 1.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Clocking/reset: one clock (clk). Reset is synchronous and active-high (reset), sampled on the rising edge of clk.
- Reset values (next edge with reset=1): state=IDLE, sout=1, din_ready=1, busy=0, done=0, shift register=0, counters=0.
- All outputs are registered.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- Acceptance:
  - A transfer occurs on a rising edge with din_valid=1 and din_ready=1.
  - din is copied into the shift register; din changes after acceptance have no effect.
  - din_ready=1 only in IDLE.
- IDLE -> START on acceptance. Next cycle: sout=0, busy=1, din_ready=0. Latency from accept edge to start bit is 1 cycle.
- Bit timing: each bit is held exactly DIV cycles.
  - Period counter counts 0..DIV-1.
  - The bit advances when the counter equals DIV-1; the counter then wraps to 0.
- START -> DATA after DIV cycles.
- DATA:
  - sout = shreg[0]; shift right by one per bit period.
  - Bit counter 0..DATA_W-1.
  - After DATA_W bit periods -> STOP (or PARITY if enabled).
- STOP: sout=1 for DIV cycles, then -> IDLE.
- On the IDLE re-entry cycle: done=1 for exactly one cycle, busy=0, din_ready=1.
  - If din_valid=1 in that same cycle, the next frame is accepted. This gives back-to-back frames with no extra idle bit.
- Frame length: (DATA_W+2)*DIV cycles, plus DIV when parity is enabled.
- din_valid while busy: ignored, no acceptance. Upstream must hold din_valid until din_ready.
- Reset mid-frame: frame aborted; on the next edge sout=1, IDLE, no done pulse.
- Reset and din_valid together: reset wins, nothing accepted.
- busy=1 from the cycle after acceptance through the last STOP cycle inclusive.

Optional Feature:
- Macro: BYTE_SERIALIZER_PARITY_EN.
- Defined:
  - Parity is computed at acceptance as the XOR of din.
  - A PARITY state follows DATA, driving even parity (XOR of all data bits) for DIV cycles, then -> STOP.
  - Frame = (DATA_W+3)*DIV cycles.
- Undefined: DATA -> STOP directly; no parity logic is synthesized.

Test Plan:
1. Reset and idle: reset=1 for 2 cycles with din_valid=1, then release -> sout=1, din_ready=1, busy=0, done=0; no frame starts during reset.
2. Single frame, DIV=4, din=8'hA5 accepted at edge T:
   - sout over 4-cycle slots = 0,1,0,1,0,0,1,0,1,1.
   - busy=1 for cycles T+1..T+40.
   - done=1 only at T+41.
3. Back-to-back: din_valid held high with 8'h00 then 8'hFF (switched at the done cycle):
   - Second start bit begins at T+42.
   - No idle gap.
   - Second data slots are all 1.
4. Ignored input: pulse din_valid with 8'h3C while busy -> no acceptance, din_ready=0, the current frame bits are unchanged.
5. Reset mid-frame: assert reset during data bit 3 -> sout=1 and busy=0 next cycle, no done pulse; a following accept of 8'h81 sends a correct full frame.
6. Parity (macro defined, DIV=1):
   - din=8'h07 -> sout sequence 0,1,1,1,0,0,0,0,0,1,1 (parity=1).
   - din=8'hA5 -> parity slot=0.
